muldiv_ctrl: RTL and testbench

- Multi-cycle multiply/divide sequencer beside the execute stage of the 5-stage MIPS pipeline.
- Accepts MULT/DIV issue from E and runs a WIDTH-step shift-add multiply or restoring divide.
- Holds BusyE high so the hazard unit stalls F/D/E; writes the HI/LO registers read by MFHI/MFLO.

---
 rtl/muldiv_pkg.sv | 17 +
 rtl/muldiv_step.sv | 42 ++++
 rtl/muldiv_ctrl.sv | 223 ++++++++++++++++++++++
 tb/tb_muldiv_ctrl.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// Shared types and constants for the multi-cycle multiply/divide sequencer.
package muldiv_pkg;

   localparam int DEF_WIDTH     = 32;
   localparam int DEF_CNT_WIDTH = 6;

   localparam logic OP_MULT = 1'b0;
   localparam logic OP_DIV  = 1'b1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MUL  = 2'd1,
      DIV  = 2'd2,
      DONE = 2'd3
   } state_t;

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the shift-add multiply or restoring divide on a 2*WIDTH accumulator.
module muldiv_step
   import muldiv_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
) (
   input  logic               op,
   input  logic [2*WIDTH-1:0] acc,
   input  logic [WIDTH-1:0]   opnd,
   output logic [2*WIDTH-1:0] acc_next
);

   logic [WIDTH:0] addend_s;
   logic [WIDTH:0] sum_s;
   logic [WIDTH:0] rem_sh_s;
   logic [WIDTH:0] trial_s;

   // Both datapaths are evaluated; op selects which result feeds the accumulator
   always_comb begin
      addend_s = {(WIDTH+1){1'b0}};
      if (acc[0]) begin
         addend_s = {1'b0, opnd};
      end else begin
         addend_s = {(WIDTH+1){1'b0}};
      end
      // Carry of the upper-half add lands in the MSB after the right shift
      sum_s    = {1'b0, acc[2*WIDTH-1:WIDTH]} + addend_s;
      rem_sh_s = acc[2*WIDTH-1:WIDTH-1];
      trial_s  = rem_sh_s - {1'b0, opnd};
      acc_next = {sum_s, acc[WIDTH-1:1]};
      if (op == OP_DIV) begin
         if (!trial_s[WIDTH]) begin
            acc_next = {trial_s[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
         end else begin
            acc_next = {rem_sh_s[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
         end
      end else begin
         acc_next = {sum_s, acc[WIDTH-1:1]};
      end
   end

endmodule

// File: rtl/muldiv_ctrl.sv
// MULT/DIV sequencer: WIDTH-step iteration, stall via BusyE, HI/LO written on completion.
// Define MULDIV_SIGNED_EN to honour SignedE (magnitude conversion and result sign fix-up).
module muldiv_ctrl
   import muldiv_pkg::*;
#(
   parameter int WIDTH     = DEF_WIDTH,
   parameter int CNT_width = DEF_CNT_WIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             StartE,
   input  logic             OpE,
   input  logic             SignedE,
   input  logic [WIDTH-1:0] SrcAE,
   input  logic [WIDTH-1:0] SrcBE,
   input  logic             AbortE,
   output logic             BusyE,
   output logic             DoneE,
   output logic [WIDTH-1:0] HI,
   output logic [WIDTH-1:0] LO,
   output logic             DivZero
);

   state_t               state_r, state_n;
   logic [CNT_width-1:0] cnt_r, cnt_n;
   logic [2*WIDTH-1:0]   acc_r, acc_n;
   logic [2*WIDTH-1:0]   step_s;
   logic [WIDTH-1:0]     opnd_r, opnd_n;
   logic                 op_r, op_n;
   logic                 zdiv_r, zdiv_n;
   logic [WIDTH-1:0]     hi_r, hi_n;
   logic [WIDTH-1:0]     lo_r, lo_n;
   logic                 divzero_r, divzero_n;
   logic                 busy_s, done_s;
   logic                 start_s;
   logic [WIDTH-1:0]     a_mag_s, b_mag_s;
   logic [WIDTH-1:0]     res_hi_s, res_lo_s;

   assign start_s = StartE && !AbortE;

   muldiv_step #(.WIDTH(WIDTH)) u_step (
      .op       (op_r),
      .acc      (acc_r),
      .opnd     (opnd_r),
      .acc_next (step_s)
   );

`ifdef MULDIV_SIGNED_EN
   logic neg_res_s, neg_rem_s;
   logic neg_res_r, neg_rem_r;

   // Magnitudes at issue, sign restoration of the finished accumulator
   always_comb begin
      a_mag_s   = SrcAE;
      b_mag_s   = SrcBE;
      neg_res_s = 1'b0;
      neg_rem_s = 1'b0;
      if (SignedE) begin
         if (SrcAE[WIDTH-1]) begin
            a_mag_s = -SrcAE;
         end else begin
            a_mag_s = SrcAE;
         end
         if (SrcBE[WIDTH-1]) begin
            b_mag_s = -SrcBE;
         end else begin
            b_mag_s = SrcBE;
         end
         neg_res_s = SrcAE[WIDTH-1] ^ SrcBE[WIDTH-1];
         neg_rem_s = SrcAE[WIDTH-1];
      end else begin
         neg_res_s = 1'b0;
         neg_rem_s = 1'b0;
      end

      res_hi_s = acc_r[2*WIDTH-1:WIDTH];
      res_lo_s = acc_r[WIDTH-1:0];
      // A zero-divisor result carries the raw dividend and is never sign-adjusted
      if (zdiv_r) begin
         res_hi_s = acc_r[2*WIDTH-1:WIDTH];
      end else if (op_r == OP_MULT) begin
         if (neg_res_r) begin
            {res_hi_s, res_lo_s} = -acc_r;
         end else begin
            {res_hi_s, res_lo_s} = acc_r;
         end
      end else begin
         if (neg_res_r) begin
            res_lo_s = -acc_r[WIDTH-1:0];
         end else begin
            res_lo_s = acc_r[WIDTH-1:0];
         end
         if (neg_rem_r) begin
            res_hi_s = -acc_r[2*WIDTH-1:WIDTH];
         end else begin
            res_hi_s = acc_r[2*WIDTH-1:WIDTH];
         end
      end
   end

   // Result sign flags captured alongside the operands
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         neg_res_r <= 1'b0;
         neg_rem_r <= 1'b0;
      end else if (state_r == IDLE && start_s) begin
         neg_res_r <= neg_res_s;
         neg_rem_r <= neg_rem_s;
      end
   end
`else
   logic signed_unused_s;

   assign signed_unused_s = SignedE;
   assign a_mag_s         = SrcAE;
   assign b_mag_s         = SrcBE;
   assign res_hi_s        = acc_r[2*WIDTH-1:WIDTH];
   assign res_lo_s        = acc_r[WIDTH-1:0];
`endif

   // Next-state, datapath update and status outputs
   always_comb begin
      state_n   = state_r;
      cnt_n     = cnt_r;
      acc_n     = acc_r;
      opnd_n    = opnd_r;
      op_n      = op_r;
      zdiv_n    = zdiv_r;
      hi_n      = hi_r;
      lo_n      = lo_r;
      divzero_n = divzero_r;
      busy_s    = 1'b0;
      done_s    = 1'b0;
      case (state_r)
         IDLE: begin
            if (start_s) begin
               cnt_n  = {CNT_width{1'b0}};
               op_n   = OpE;
               zdiv_n = 1'b0;
               if (OpE == OP_DIV) begin
                  opnd_n = b_mag_s;
                  if (SrcBE == {WIDTH{1'b0}}) begin
                     acc_n   = {SrcAE, {WIDTH{1'b1}}};
                     zdiv_n  = 1'b1;
                     state_n = DONE;
                  end else begin
                     acc_n   = {{WIDTH{1'b0}}, a_mag_s};
                     state_n = DIV;
                  end
               end else begin
                  // Multiplier sits in the low half and is consumed LSB first
                  opnd_n  = a_mag_s;
                  acc_n   = {{WIDTH{1'b0}}, b_mag_s};
                  state_n = MUL;
               end
            end else begin
               state_n = IDLE;
            end
         end
         MUL, DIV: begin
            busy_s = 1'b1;
            if (AbortE) begin
               state_n = IDLE;
            end else begin
               acc_n = step_s;
               cnt_n = cnt_r + CNT_width'(1);
               if (cnt_r == CNT_width'(WIDTH - 1)) begin
                  state_n = DONE;
               end else begin
                  state_n = state_r;
               end
            end
         end
         DONE: begin
            busy_s  = 1'b1;
            state_n = IDLE;
            if (!AbortE) begin
               done_s    = 1'b1;
               hi_n      = res_hi_s;
               lo_n      = res_lo_s;
               divzero_n = zdiv_r;
            end else begin
               done_s = 1'b0;
            end
         end
         default: begin
            state_n = IDLE;
         end
      endcase
   end

   // State, counter, accumulator and architectural HI/LO registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r   <= IDLE;
         cnt_r     <= {CNT_width{1'b0}};
         acc_r     <= {(2*WIDTH){1'b0}};
         opnd_r    <= {WIDTH{1'b0}};
         op_r      <= OP_MULT;
         zdiv_r    <= 1'b0;
         hi_r      <= {WIDTH{1'b0}};
         lo_r      <= {WIDTH{1'b0}};
         divzero_r <= 1'b0;
      end else begin
         state_r   <= state_n;
         cnt_r     <= cnt_n;
         acc_r     <= acc_n;
         opnd_r    <= opnd_n;
         op_r      <= op_n;
         zdiv_r    <= zdiv_n;
         hi_r      <= hi_n;
         lo_r      <= lo_n;
         divzero_r <= divzero_n;
      end
   end

   assign BusyE   = busy_s;
   assign DoneE   = done_s;
   assign HI      = hi_r;
   assign LO      = lo_r;
   assign DivZero = divzero_r;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Directed bench for muldiv_ctrl: latency, results, divide-by-zero, abort and reset.
module tb_muldiv_ctrl;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        StartE, OpE, SignedE, AbortE;
   logic [31:0] SrcAE, SrcBE;
   logic        BusyE, DoneE, DivZero;
   logic [31:0] HI, LO;

   int checks = 0;
   int errors = 0;
   int done_cyc;
   int busy_cnt;

   muldiv_ctrl #(.WIDTH(32), .CNT_width(6)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .StartE  (StartE),
      .OpE     (OpE),
      .SignedE (SignedE),
      .SrcAE   (SrcAE),
      .SrcBE   (SrcBE),
      .AbortE  (AbortE),
      .BusyE   (BusyE),
      .DoneE   (DoneE),
      .HI      (HI),
      .LO      (LO),
      .DivZero (DivZero)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   // Issue at cycle 0, optionally inject a stray StartE or an AbortE, stop one cycle after DoneE
   task automatic run_op(input logic op, input logic [31:0] a, input logic [31:0] b,
                         input logic sg, input int inj, input int abt);
      OpE = op; SrcAE = a; SrcBE = b; SignedE = sg; StartE = 1'b1; AbortE = 1'b0;
      done_cyc = -1;
      busy_cnt = 0;
      for (int c = 1; c <= 40; c++) begin
         next_cycle();
         StartE = (c == inj);
         if (c == inj) begin
            OpE = 1'b0; SrcAE = 32'd3; SrcBE = 32'd3;
         end
         AbortE = (c == abt);
         #1;
         if (BusyE) busy_cnt++;
         if (DoneE) begin
            done_cyc = c;
            break;
         end
      end
      next_cycle();
      StartE = 1'b0;
      AbortE = 1'b0;
      #1;
   endtask

   initial begin
      rst_n = 1'b0; StartE = 1'b0; OpE = 1'b0; SignedE = 1'b0; AbortE = 1'b0;
      SrcAE = 32'd0; SrcBE = 32'd0;
      #2;
      chk("rst_busy", BusyE, 1'b0);
      chk("rst_done", DoneE, 1'b0);
      chk("rst_hilo", {HI, LO}, 64'd0);
      chk("rst_divzero", DivZero, 1'b0);
      next_cycle();
      next_cycle();
      rst_n = 1'b1;
      #1;

      run_op(1'b0, 32'd7, 32'd6, 1'b0, 0, 0);
      chk("mul7x6_done_cyc", done_cyc, 33);
      chk("mul7x6_busy_cnt", busy_cnt, 33);
      chk("mul7x6_hilo", {HI, LO}, 64'd42);
      chk("mul7x6_idle", {BusyE, DoneE}, 2'b00);

      run_op(1'b0, 32'hFFFF_FFFF, 32'd2, 1'b0, 0, 0);
      chk("mulmax_hilo", {HI, LO}, 64'h0000_0001_FFFF_FFFE);

      run_op(1'b1, 32'd100, 32'd7, 1'b0, 5, 0);
      chk("div100_done_cyc", done_cyc, 33);
      chk("div100_hi", HI, 32'd2);
      chk("div100_lo", LO, 32'd14);
      chk("div100_divzero", DivZero, 1'b0);
      chk("div100_no_restart", BusyE, 1'b0);

      run_op(1'b1, 32'h1234, 32'd0, 1'b0, 0, 0);
      chk("divz_done_cyc", done_cyc, 1);
      chk("divz_busy_cnt", busy_cnt, 1);
      chk("divz_hilo", {HI, LO}, 64'h0000_1234_FFFF_FFFF);
      chk("divz_flag", DivZero, 1'b1);

      run_op(1'b1, 32'd9, 32'd3, 1'b0, 0, 0);
      chk("div9_hilo", {HI, LO}, 64'h0000_0000_0000_0003);
      chk("div9_divzero_clr", DivZero, 1'b0);

      run_op(1'b0, 32'd5, 32'd5, 1'b0, 0, 10);
      chk("abort10_no_done", done_cyc, -1);
      chk("abort10_busy_cnt", busy_cnt, 10);
      chk("abort10_hilo", {HI, LO}, 64'h0000_0000_0000_0003);

      run_op(1'b0, 32'd5, 32'd5, 1'b0, 0, 33);
      chk("abort33_no_done", done_cyc, -1);
      chk("abort33_busy_cnt", busy_cnt, 33);
      chk("abort33_hilo", {HI, LO}, 64'h0000_0000_0000_0003);

      // Load nonzero HI/LO/DivZero, then reset in the middle of a DIV
      run_op(1'b1, 32'h55, 32'd0, 1'b0, 0, 0);
      chk("divz55_flag", DivZero, 1'b1);
      OpE = 1'b1; SrcAE = 32'd1000; SrcBE = 32'd3; StartE = 1'b1;
      next_cycle();
      StartE = 1'b0;
      next_cycle();
      next_cycle();
      chk("middiv_busy", BusyE, 1'b1);
      rst_n = 1'b0;
      #1;
      chk("async_rst_outs", {BusyE, DoneE, DivZero}, 3'b000);
      chk("async_rst_hilo", {HI, LO}, 64'd0);
      next_cycle();
      rst_n = 1'b1;
      next_cycle();

      OpE = 1'b0; SrcAE = 32'd2; SrcBE = 32'd2; StartE = 1'b1; AbortE = 1'b1;
      next_cycle();
      StartE = 1'b0; AbortE = 1'b0;
      #1;
      chk("idle_abort_wins", BusyE, 1'b0);
      next_cycle();
      chk("idle_abort_hilo", {HI, LO}, 64'd0);

`ifdef MULDIV_SIGNED_EN
      run_op(1'b1, 32'hFFFF_FFF9, 32'd2, 1'b1, 0, 0);
      chk("sdiv_done_cyc", done_cyc, 33);
      chk("sdiv_hilo", {HI, LO}, 64'hFFFF_FFFF_FFFF_FFFD);
      run_op(1'b0, 32'hFFFF_FFFD, 32'd4, 1'b1, 0, 0);
      chk("smul_done_cyc", done_cyc, 33);
      chk("smul_hilo", {HI, LO}, 64'hFFFF_FFFF_FFFF_FFF4);
`else
      run_op(1'b1, 32'hFFFF_FFF9, 32'd2, 1'b1, 0, 0);
      chk("udiv_signed_ignored", {HI, LO}, 64'h0000_0001_7FFF_FFFC);
      run_op(1'b0, 32'hFFFF_FFFD, 32'd4, 1'b1, 0, 0);
      chk("umul_signed_ignored", {HI, LO}, 64'h0000_0003_FFFF_FFF4);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
